// File: rtl/calc_pkg.sv
// Shared definitions for the sequential multiplier: FSM state encoding,
// default operand width and a small width helper.
package calc_pkg;

    // Default operand width; the product is twice as wide.
    localparam int W_DEFAULT = 8;

    // Three-phase control: wait for a request, iterate, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter width: one bit more than needed to index W steps.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mul8_seq.sv
// Unsigned shift-add multiplier: one partial-product step per clock,
// exactly W steps per operation, result held until the next completion.
module mul8_seq
    import calc_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = cnt_width(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

    state_t          state_q, state_d;
    logic [W-1:0]    mcand_q, mcand_d;
    logic [W-1:0]    mplier_q, mplier_d;
    // One spare bit above the product so the add carry survives until the shift.
    logic [2*W:0]    acc_q, acc_d;
    logic [2*W:0]    acc_sum;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*W-1:0]  product_q, product_d;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operands, accumulator, step counter, result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Partial-product add into the upper half; acc_q[2W] is always zero
    // between steps, so the full-width add only ever carries into that bit.
    always_comb begin
        acc_sum = acc_q;
        if (mplier_q[0]) begin
            acc_sum = acc_q + {1'b0, mcand_q, {W{1'b0}}};
        end
    end

    // Next-state and output decode; everything holds unless a phase moves it.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = a;
                    mplier_d = b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end

            RUN: begin
                busy     = 1'b1;
                // Shift right: carry lands in the product MSB, LSB retires.
                acc_d    = acc_sum >> 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // Result is captured only here, so it holds through IDLE.
                    product_d = acc_d[2*W-1:0];
                    state_d   = DONE;
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign product = product_q;

endmodule

// File: tb/tb_mul8_seq.sv
// Directed bench for mul8_seq: a cycle-timeline reference model checked
// every cycle, plus literal expectations for the hand-worked operations.
module tb_mul8_seq;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    mul8_seq #(.W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference timeline: m_t counts cycles since acceptance
    // (0 = idle, 1..W = busy, W+1 = done cycle).
    int             m_t = 0;
    logic [2*W-1:0] m_pend = '0;
    logic [2*W-1:0] m_prod = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t    <= 0;
            m_prod <= '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_pend <= {8'd0, a} * {8'd0, b};
                m_t    <= 1;
            end
        end else if (m_t < W) begin
            m_t <= m_t + 1;
        end else if (m_t == W) begin
            m_prod <= m_pend;
            m_t    <= W + 1;
        end else begin
            m_t <= 0;
        end
    end

    // Compare process: every cycle once reset has established known state.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, (m_t >= 1 && m_t <= W)});
            check("done", {31'd0, done}, {31'd0, (m_t == W + 1)});
            check("product", {16'd0, product}, {16'd0, m_prod});
        end
    end

    // Caller is at a negedge with the DUT idle for the next edge.
    // Ends at the negedge of the IDLE cycle after completion.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                         input logic [2*W-1:0] exp, input bit spam);
        a = ta;
        b = tb_v;
        start = 1'b1;
        for (int i = 1; i <= W; i++) begin
            @(negedge clk);
            if (spam) begin
                start = 1'b1;
                a = 8'd9;
                b = 8'd9;
            end else begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            check("op_busy", {31'd0, busy}, 32'd1);
            check("op_nodone", {31'd0, done}, 32'd0);
        end
        @(negedge clk);
        check("op_done", {31'd0, done}, 32'd1);
        check("op_busy_done", {31'd0, busy}, 32'd0);
        check("op_product", {16'd0, product}, {16'd0, exp});
        @(negedge clk);
        start = 1'b0;
        check("op_idle_done", {31'd0, done}, 32'd0);
        check("op_idle_busy", {31'd0, busy}, 32'd0);
        check("op_hold", {16'd0, product}, {16'd0, exp});
        $display("[TB] op a=%0d b=%0d product=%0d expected=%0d", ta, tb_v, product, exp);
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", {16'd0, product}, 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;

        do_op(8'd13, 8'd11, 16'h008F, 1'b0);
        do_op(8'd255, 8'd255, 16'hFE01, 1'b0);
        do_op(8'd0, 8'd200, 16'h0000, 1'b0);
        do_op(8'd200, 8'd0, 16'h0000, 1'b0);
        do_op(8'd3, 8'd4, 16'd12, 1'b1);
        repeat (W + 2) begin
            @(negedge clk);
            check("ignored_start", {31'd0, done}, 32'd0);
        end

        // Reset in the middle of RUN.
        a = 8'd7;
        b = 8'd7;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", {16'd0, product}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_nodone", {31'd0, done}, 32'd0);
        end
        do_op(8'd2, 8'd5, 16'd10, 1'b0);

        // Back-to-back random operations; model checks each completion.
        start = 1'b1;
        repeat (8 * (W + 2)) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            if (done) $display("[TB] b2b product=%0d expected=%0d", product, m_prod);
        end
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul8_seq.md
MUL8_SEQ -- requirements
Module: mul8_seq

Interface
REQ-001 Parameter: W, 8, operand width in bits; product width is 2*W.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 a  input  W  multiplicand, unsigned.
REQ-006 b  input  W  multiplier, unsigned.
REQ-007 busy  output  1  high while a multiplication is in progress (RUN).
REQ-008 done  output  1  one-cycle pulse; product valid and new.
REQ-009 product  output  2*W  unsigned result a*b.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE with start=1 at edge k, the block SHALL latch a and b, clear the accumulator and step counter, and enter RUN.
REQ-012 In RUN, the block SHALL perform one shift-add step per edge: if the multiplier LSB is 1, add the multiplicand to the accumulator upper half; then shift the accumulator and multiplier right by 1, with the add carry entering the accumulator MSB.
REQ-013 The block SHALL take exactly W RUN steps with no early termination; the W-th step occurs at edge k+W, and the FSM enters DONE.
REQ-014 In DONE, product SHALL equal a*b (mod 2^(2W), which is exact), and done SHALL be 1 for exactly that cycle; at edge k+W+1, the FSM SHALL return to IDLE.
REQ-015 Total latency SHALL be W+1 edges from start to return to IDLE; done is visible in the cycle after edge k+W.
REQ-016 busy SHALL be 1 exactly in RUN and 0 in IDLE and DONE.
REQ-017 start in RUN or DONE SHALL be ignored; a new operation is accepted only in IDLE.
REQ-018 a and b changes after edge k SHALL NOT affect the result in progress.
REQ-019 product SHALL update only on entry to DONE and SHALL hold its value until the next completion.
REQ-020 Zero operands SHALL follow the same W-step timing and produce 0.
REQ-021 The accumulator SHALL be 2*W+1 bits wide internally so the add carry is never lost.

Reset
REQ-022 On rst=1, immediately and regardless of clk, the FSM SHALL go to IDLE and clear the counter and internal registers; busy=0, done=0, product=0.
REQ-023 An assertion of reset in the middle of RUN SHALL abort the operation; no done pulse SHALL follow, and product SHALL read 0.
REQ-024 After rst deasserts, the first start SHALL be accepted at the first rising edge.

Structure
REQ-025 The shared package calc_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the default operand width constant 8.
REQ-026 The design SHALL be a single module with no sub-module; the counter width SHALL be clog2(W)+1.

Verification
REQ-027 a=13, b=11, start at edge k: busy=1 over edges k+1..k+8; done=1 after edge k+8 with product=0x008F (143); IDLE after edge k+9.
REQ-028 a=255, b=255: product=0xFE01 (65025) with done after edge k+8, which checks carry retention.
REQ-029 a=0, b=200, then a=200, b=0: product=0 both times, with the same 8-step timing.
REQ-030 Start a=3, b=4, then pulse start with a=9, b=9 during RUN and DONE: a single done with product=12; the second request is ignored.
REQ-031 Assert rst at edge k+4 of a=7, b=7: busy, done and product drop to 0 immediately with no done pulse; a following start with a=2, b=5 gives product=10.
REQ-032 Random back-to-back operations (start asserted in each IDLE cycle): every done product equals the reference a*b of the operands latched at its accepting edge.
